// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential restoring divider: default widths and
// FSM state encodings.
package seq_div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CW_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_div_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_div_if #(
  parameter int DW = 16,
  parameter int VW = 8
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quo;
  logic [VW-1:0] rem;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quo, rem, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quo, rem, div_zero
  );

endinterface

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module seq_div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   p,
  input  logic          qmsb,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   p_next,
  output logic          qbit
);

  logic [VW+1:0] shifted;
  logic [VW+2:0] diff;

  // Two spare top bits give a clean sign bit for the trial subtraction.
  always_comb begin
    shifted = {p, qmsb};
    diff    = {1'b0, shifted} - {3'b000, divisor};
    qbit    = (diff[VW+2:VW+1] == 2'b00);
    p_next  = qbit ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done
// handshake, divide-by-zero reported without iterating.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input logic     clk,
  input logic     clr,
  seq_div_if.slave bus
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW:0]   p;
  logic [DW-1:0] q;
  logic [VW-1:0] dvs;
  logic [DW-1:0] quo;
  logic [VW-1:0] rem;
  logic          div_zero;

  logic [VW:0]   p_next;
  logic          qbit;
  logic [DW-1:0] q_next;

  seq_div_step #(.VW(VW)) u_step (
    .p       (p),
    .qmsb    (q[DW-1]),
    .divisor (dvs),
    .p_next  (p_next),
    .qbit    (qbit)
  );

  assign q_next = {q[DW-2:0], qbit};

  // Results only update at the end of a run (or on a zero divisor), so they
  // hold stable for the controller until the next accepted start finishes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      p        <= '0;
      q        <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quo      <= '1;
              rem      <= '0;
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              dvs   <= bus.divisor;
              p     <= '0;
              q     <= bus.dividend;
              cnt   <= CW'(DW);
              state <= RUN;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo      <= q_next;
            rem      <= p_next[VW-1:0];
            div_zero <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.quo      = quo;
  assign bus.rem      = rem;
  assign bus.div_zero = div_zero;

endmodule

// File: tb/tb_seq_div.sv
// Directed-vector bench for seq_div: handshake timing, boundary quotients,
// divide-by-zero, ignored restart and mid-run reset.
module tb_seq_div;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  seq_div_if #(.DW(16), .VW(8)) bus ();

  seq_div #(.DW(16), .VW(8), .CW(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'hA5A5;
    bus.divisor  = 8'h5A;
  endtask

  // Runs one division and checks busy length, single done pulse and results.
  task automatic runDiv(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input int exp_busy, input logic [15:0] exp_q,
                        input logic [7:0] exp_r, input logic exp_dz);
    int busy_cycles;
    bit got_done;
    busy_cycles = 0;
    got_done    = 1'b0;
    applyStimulus(a, b);
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (bus.done) got_done = 1'b1;
      else begin
        if (bus.busy) busy_cycles++;
        @(negedge clk);
      end
    end
    checkOutput({tag, " done seen"}, 32'(got_done), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp_busy));
    checkOutput({tag, " quo"}, 32'(bus.quo), 32'(exp_q));
    checkOutput({tag, " rem"}, 32'(bus.rem), 32'(exp_r));
    checkOutput({tag, " div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
    @(negedge clk);
    checkOutput({tag, " done single pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int done_pulses;
    checks       = 0;
    errors       = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    clr          = 1'b1;
    #100;
    clr = 1'b0;
    #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset quo", 32'(bus.quo), 32'd0);
    checkOutput("reset rem", 32'(bus.rem), 32'd0);
    checkOutput("reset div_zero", 32'(bus.div_zero), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("idle busy", 32'(bus.busy), 32'd0);
    checkOutput("idle done", 32'(bus.done), 32'd0);

    runDiv("100/7", 16'd100, 8'd7, 16, 16'd14, 8'd2, 1'b0);
    runDiv("65535/1", 16'd65535, 8'd1, 16, 16'd65535, 8'd0, 1'b0);
    runDiv("5/10", 16'd5, 8'd10, 16, 16'd0, 8'd5, 1'b0);
    runDiv("65535/255", 16'd65535, 8'd255, 16, 16'd257, 8'd0, 1'b0);
    runDiv("12345/100", 16'd12345, 8'd100, 16, 16'd123, 8'd45, 1'b0);
    runDiv("1000/0", 16'd1000, 8'd0, 0, 16'hFFFF, 8'd0, 1'b1);
    runDiv("50/5", 16'd50, 8'd5, 16, 16'd10, 8'd0, 1'b0);

    // Restart attempt during iteration 5 must be ignored.
    done_pulses = 0;
    applyStimulus(16'd200, 8'd3);
    repeat (4) @(negedge clk);
    bus.dividend = 16'd9;
    bus.divisor  = 8'd9;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        done_pulses++;
        checkOutput("200/3 quo", 32'(bus.quo), 32'd66);
        checkOutput("200/3 rem", 32'(bus.rem), 32'd2);
      end
      @(negedge clk);
    end
    checkOutput("200/3 done pulses", 32'(done_pulses), 32'd1);

    // Reset during iteration 8 aborts with no done pulse.
    done_pulses = 0;
    applyStimulus(16'd1234, 8'd17);
    repeat (7) @(negedge clk);
    checkOutput("abort busy before clr", 32'(bus.busy), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort quo", 32'(bus.quo), 32'd0);
    checkOutput("abort rem", 32'(bus.rem), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done) done_pulses++;
      @(negedge clk);
    end
    checkOutput("abort done pulses", 32'(done_pulses), 32'd0);

    runDiv("1234/17", 16'd1234, 8'd17, 16, 16'd72, 8'd10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
